// File: rtl/argmax10_seq.sv
// argmax10_seq: sequential arg-max over ten signed values.
// On start (in IDLE) all ten inputs are captured. The unit then scans one
// element per cycle and reports the lowest index of the largest value after
// nine scan cycles. done is sticky until reset.
module argmax10_seq #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] inputs [10],
    input  logic                    start,
    output logic [3:0]              idx,
    output logic                    done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;

    logic signed [WIDTH-1:0] captured [10];
    logic signed [WIDTH-1:0] cur_max;
    logic [3:0]              cur_idx;
    logic [3:0]              cnt;

    logic signed [WIDTH-1:0] cand;
    logic                    take_new;
    logic [3:0]              next_idx;
    logic                    last;

    // Signed strict compare: ties keep the earlier (lower) index.
    function automatic logic is_greater(input logic signed [WIDTH-1:0] a,
                                        input logic signed [WIDTH-1:0] b);
        return a > b;
    endfunction

    // Compare the current candidate against the running maximum.
    always_comb begin
        cand     = captured[cnt];
        take_new = is_greater(cand, cur_max);
        next_idx = take_new ? cnt : cur_idx;
        last     = (cnt == 4'd9);
    end

    // State register; reset has priority over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE is terminal.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start) next_state = S_SCAN;
            S_SCAN: if (last)  next_state = S_DONE;
            S_DONE: next_state = S_DONE;
            default: next_state = S_IDLE;
        endcase
    end

    // Capture bank: loaded once at start so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!reset && state == S_IDLE && start) begin
            captured <= inputs;
        end
    end

    // Running maximum, scan counter and the registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_max <= '0;
            cur_idx <= 4'd0;
            cnt     <= 4'd0;
            idx     <= 4'd0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_max <= inputs[0];
                        cur_idx <= 4'd0;
                        cnt     <= 4'd1;
                    end
                end
                S_SCAN: begin
                    if (take_new) begin
                        cur_max <= cand;
                    end
                    cur_idx <= next_idx;
                    cnt     <= cnt + 4'd1;
                    if (last) begin
                        idx  <= next_idx;
                        done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax10_seq.sv
// Bench for argmax10_seq: directed vectors, a behavioural reference model
// checked every cycle, and hand-computed literal expectations.
module tb_argmax10_seq;

    localparam int WIDTH = 8;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic signed [WIDTH-1:0] inputs [10];
    logic [3:0]              idx;
    logic                    done;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    argmax10_seq #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .inputs (inputs),
        .start  (start),
        .idx    (idx),
        .done   (done)
    );

    // Reference arg-max: lowest index among the largest signed values.
    function automatic int ref_argmax(input logic signed [WIDTH-1:0] v [10]);
        int best = 0;
        for (int i = 1; i < 10; i++) begin
            if (v[i] > v[best]) best = i;
        end
        return best;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Behavioural model: a search accepted at edge k publishes its answer at edge k+9.
    logic m_valid = 1'b0;
    logic m_busy  = 1'b0;
    logic m_done  = 1'b0;
    int   m_idx   = 0;
    int   m_res   = 0;
    int   m_left  = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_idx   <= 0;
            m_left  <= 0;
        end else if (m_valid && !m_busy && !m_done && start) begin
            m_res  <= ref_argmax(inputs);
            m_busy <= 1'b1;
            m_left <= 9;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_idx  <= m_res;
            end
            m_left <= m_left - 1;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_done", int'(done), int'(m_done));
            check("model_idx", int'(idx), m_idx);
        end
    end

    task automatic load(input int v [10]);
        for (int i = 0; i < 10; i++) inputs[i] = v[i][WIDTH-1:0];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Called just after the start edge; counts edges until done (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // One start pulse, then wait for the result.
    task automatic run_pulse(input string name, input int exp_idx);
        int c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(c);
        check({name, "_lat"}, c, 9);
        check({name, "_idx"}, int'(idx), exp_idx);
        check({name, "_ref"}, ref_argmax(inputs), exp_idx);
    endtask

    initial begin
        int c;
        reset = 1'b1;
        start = 1'b0;
        load('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk);
        @(negedge clk);
        check("reset_done", int'(done), 0);
        check("reset_idx", int'(idx), 0);
        reset = 1'b0;

        // Ascending values, start held high throughout.
        load('{0, 1, 2, 3, 4, 5, 6, 7, 8, 9});
        start = 1'b1;
        @(negedge clk);
        check("asc_idx_during_scan", int'(idx), 0);
        wait_done(c);
        check("asc_lat", c, 9);
        check("asc_idx", int'(idx), 9);
        repeat (20) @(negedge clk);
        check("asc_hold_done", int'(done), 1);
        check("asc_hold_idx", int'(idx), 9);
        start = 1'b0;

        // Ties at 127: lowest index wins.
        do_reset();
        load('{5, -3, 127, 127, 0, -128, 127, 1, 2, 3});
        run_pulse("ties", 2);

        // All equal at the most negative value.
        do_reset();
        load('{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128});
        run_pulse("all_min", 0);

        // All negative: signed compare must pick -1.
        do_reset();
        load('{-5, -4, -100, -1, -2, -9, -7, -3, -8, -6});
        run_pulse("neg", 3);

        // Inputs changed after the start edge must not matter.
        do_reset();
        load('{0, 0, 0, 0, 0, 0, 0, 0, 0, 50});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        inputs[9] = -8'sd1;
        inputs[4] = 8'sd100;
        wait_done(c);
        check("capture_lat", c, 9);
        check("capture_idx", int'(idx), 9);

        // Reset in the middle of a scan aborts it.
        do_reset();
        load('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_done", int'(done), 0);
        check("abort_idx", int'(idx), 0);
        repeat (12) @(negedge clk);
        check("abort_stays_idle", int'(done), 0);
        load('{0, 0, 0, 0, 0, 0, 77, 0, 0, 0});
        run_pulse("after_abort", 6);

        // Reset and start together: reset wins, unit stays idle.
        do_reset();
        load('{1, 9, 3, 2, 0, 0, 0, 0, 0, 0});
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_start_done", int'(done), 0);
        check("rst_start_idx", int'(idx), 0);
        run_pulse("rst_start_then", 1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
